// File: rtl/herring_bus_sequencer.sv
// 6502 PHI0 generator: LOW/HIGH/STRETCH phase machine with address-decoded fixed waits,
// externally requested extensions, early-release RAM write strobe and a bus-cycle counter.
module herring_bus_sequencer #(
    parameter int unsigned HALF_PERIOD = 25,
    parameter int unsigned WAIT_IO     = 2,
    parameter int unsigned WAIT_MEM    = 0,
    parameter int unsigned MAX_EXT     = 8
) (
    input  logic        i_clk_src,
    input  logic        i_reset_n,
    input  logic [5:0]  i_address,
    input  logic        i_rw,
    input  logic        i_wait_req,
    output logic        o_cpu_clk_in,
    output logic        o_ram_we_n,
    output logic        o_cycle_start,
    output logic        o_stretch_active,
    output logic [15:0] o_cycle_count
);

    typedef enum logic [1:0] {StLow, StHigh, StStretch} state_e;

    localparam logic [7:0] SegLast = 8'(HALF_PERIOD - 1);
    localparam logic [3:0] WaitIo  = 4'(WAIT_IO);
    localparam logic [3:0] WaitMem = 4'(WAIT_MEM);
    localparam logic [3:0] MaxExt  = 4'(MAX_EXT);

    state_e      r_state;
    logic [7:0]  r_seg_cnt;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  r_ext_cnt;
    logic        r_rw;
    logic        r_cpu_clk;
    logic        r_ram_we_n;
    logic        r_cycle_start;
    logic        r_stretch;
    logic [15:0] r_cycle_count;

    state_e      w_state_d;
    logic [7:0]  w_seg_d;
    logic [3:0]  w_wait_d;
    logic [3:0]  w_ext_d;
    logic        w_rw_d;
    logic        w_seg_end;
    logic        w_rise;
    logic        w_io_hit;
    logic        w_final;
    logic        w_ram_we_n_d;

    // I/O window 0x8000-0x87FF spans address[15:10] = 10000x; bit 10 is a don't-care.
    assign w_io_hit = ((i_address | 6'b000001) == 6'b100001);

    always_comb begin
        w_state_d = r_state;
        w_wait_d  = r_wait_cnt;
        w_ext_d   = r_ext_cnt;
        w_rw_d    = r_rw;
        w_rise    = 1'b0;
        w_seg_end = (r_seg_cnt == SegLast);
        w_seg_d   = w_seg_end ? 8'd0 : r_seg_cnt + 8'd1;

        if (w_seg_end) begin
            unique case (r_state)
                StLow: begin
                    w_rw_d    = i_rw;
                    w_wait_d  = w_io_hit ? WaitIo : WaitMem;
                    w_ext_d   = 4'd0;
                    w_state_d = StHigh;
                    w_rise    = 1'b1;
                end
                StHigh, StStretch: begin
                    if (r_wait_cnt != 4'd0) begin
                        w_wait_d  = r_wait_cnt - 4'd1;
                        w_state_d = StStretch;
                    end else if (i_wait_req && (r_ext_cnt < MaxExt)) begin
                        w_ext_d   = r_ext_cnt + 4'd1;
                        w_state_d = StStretch;
                    end else begin
                        w_state_d = StLow;
                    end
                end
                default: w_state_d = StLow;
            endcase
        end

        // Entering the last clk of a segment that will end the high phase. The wait request
        // is looked at one clk early here so the strobe can release ahead of PHI2 falling.
        w_final = (w_state_d != StLow) && (w_seg_d == SegLast) && (w_wait_d == 4'd0) &&
                  (!i_wait_req || (w_ext_d >= MaxExt));

        w_ram_we_n_d = !((w_state_d != StLow) && !w_rw_d && !w_final);
    end

    always_ff @(posedge i_clk_src or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StLow;
            r_seg_cnt     <= 8'd0;
            r_wait_cnt    <= 4'd0;
            r_ext_cnt     <= 4'd0;
            r_rw          <= 1'b1;
            r_cpu_clk     <= 1'b0;
            r_ram_we_n    <= 1'b1;
            r_cycle_start <= 1'b0;
            r_stretch     <= 1'b0;
            r_cycle_count <= 16'd0;
        end else begin
            r_state       <= w_state_d;
            r_seg_cnt     <= w_seg_d;
            r_wait_cnt    <= w_wait_d;
            r_ext_cnt     <= w_ext_d;
            r_rw          <= w_rw_d;
            r_cpu_clk     <= (w_state_d != StLow);
            r_ram_we_n    <= w_ram_we_n_d;
            r_cycle_start <= w_rise;
            r_stretch     <= (w_state_d == StStretch);
            if (w_rise) begin
                r_cycle_count <= r_cycle_count + 16'd1;
            end
        end
    end

    assign o_cpu_clk_in     = r_cpu_clk;
    assign o_ram_we_n       = r_ram_we_n;
    assign o_cycle_start    = r_cycle_start;
    assign o_stretch_active = r_stretch;
    assign o_cycle_count    = r_cycle_count;

endmodule

// File: tb/tb_herring_bus_sequencer.sv
// Directed bench for herring_bus_sequencer: phase lengths, stretches, write strobe,
// mid-stretch reset and counter wrap, all sampled on the falling edge of clk_src.
module tb_herring_bus_sequencer;

    localparam int Limit = 2000;

    logic        clk;
    logic        rst_n;
    logic [5:0]  addr;
    logic        rw;
    logic        wreq;
    logic        cpu_clk;
    logic        ram_we_n;
    logic        cyc_start;
    logic        stretch;
    logic [15:0] cyc_count;

    int vectors;
    int miscompares;
    int hi, lo, we, st, cs, last_we, we_low_phase, n;

    herring_bus_sequencer dut (
        .i_clk_src        (clk),
        .i_reset_n        (rst_n),
        .i_address        (addr),
        .i_rw             (rw),
        .i_wait_req       (wreq),
        .o_cpu_clk_in     (cpu_clk),
        .o_ram_we_n       (ram_we_n),
        .o_cycle_start    (cyc_start),
        .o_stretch_active (stretch),
        .o_cycle_count    (cyc_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s timeout after %0d clks", tag, Limit);
    endtask

    // Counts clks from now until cpu_clk is seen high; leaves us on the rise sample.
    task automatic wait_rise(input string tag, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (cpu_clk !== 1'b1 && cnt < Limit);
        if (cnt >= Limit) timeout(tag);
    endtask

    // Called on a rise sample; measures one full period and returns on the next rise sample.
    // pulse_at >= 0 raises wait_req for the one clk preceding high-phase edge pulse_at+1.
    task automatic measure(input string tag, input int pulse_at);
        int g;
        hi = 0; lo = 0; we = 0; st = 0; cs = 0; last_we = 0; we_low_phase = 0; g = 0;
        while (cpu_clk === 1'b1 && g < Limit) begin
            if (hi == pulse_at) wreq = 1'b1;
            else if (pulse_at >= 0 && hi == pulse_at + 1) wreq = 1'b0;
            hi++;
            if (ram_we_n === 1'b0) we++;
            if (stretch === 1'b1) st++;
            if (cyc_start === 1'b1) cs++;
            last_we = int'(ram_we_n);
            @(negedge clk);
            g++;
        end
        while (cpu_clk === 1'b0 && g < Limit) begin
            lo++;
            if (ram_we_n === 1'b0) we_low_phase++;
            if (cyc_start === 1'b1) cs++;
            @(negedge clk);
            g++;
        end
        if (g >= Limit) timeout(tag);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        addr  = 6'h00;
        rw    = 1'b1;
        wreq  = 1'b0;

        // Reset hold
        repeat (5) @(negedge clk);
        chk("rst_cpu_clk", cpu_clk, 0);
        chk("rst_ram_we_n", ram_we_n, 1);
        chk("rst_cycle_start", cyc_start, 0);
        chk("rst_stretch", stretch, 0);
        chk("rst_count", cyc_count, 0);

        // Release: first rise after one full LOW segment
        rst_n = 1'b1;
        wait_rise("first_rise", n);
        chk("first_rise_delay", n, 25);
        chk("first_rise_cs", cyc_start, 1);
        chk("count_1", cyc_count, 1);

        measure("c1", -1);
        chk("c1_high", hi, 25);
        chk("c1_low", lo, 25);
        chk("c1_cs_width", cs, 1);
        chk("c1_we", we, 0);
        chk("c1_stretch", st, 0);
        chk("count_2", cyc_count, 2);

        // Next cycle goes to the I/O window
        addr = 6'b100001;
        measure("c2", -1);
        chk("c2_high", hi, 25);
        chk("count_3", cyc_count, 3);

        // Bus changes during the I/O high phase must not affect it
        addr = 6'h00;
        rw   = 1'b0;
        measure("c3_io", -1);
        chk("io_high", hi, 75);
        chk("io_stretch", st, 50);
        chk("io_low", lo, 25);
        chk("io_we", we, 0);

        rw = 1'b1;
        measure("c4_wr", -1);
        chk("wr_high", hi, 25);
        chk("wr_we_width", we, 24);
        chk("wr_we_last_high", last_we, 1);
        chk("wr_we_in_low", we_low_phase, 0);

        measure("c5_rd", -1);
        chk("rd_we", we, 0);
        chk("rd_high", hi, 25);

        // wait_req held high: capped at 1 + MAX_EXT segments
        wreq = 1'b1;
        measure("c6_hold", -1);
        chk("hold_high", hi, 225);
        chk("hold_stretch", st, 200);
        chk("hold_low", lo, 25);

        wreq = 1'b0;
        measure("c7", -1);
        chk("c7_high", hi, 25);

        // Single wait_req pulse at the first HIGH segment end; next cycle is an I/O write
        addr = 6'b100000;
        rw   = 1'b0;
        measure("c8_pulse", 24);
        chk("pulse_high", hi, 50);
        chk("pulse_stretch", st, 25);
        chk("count_9", cyc_count, 9);

        // 10 clks into the first stretch segment of the I/O write, then reset
        repeat (35) @(negedge clk);
        chk("mid_stretch", stretch, 1);
        chk("mid_we_low", ram_we_n, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cpu_clk", cpu_clk, 0);
        chk("rst_mid_ram_we_n", ram_we_n, 1);
        chk("rst_mid_count", cyc_count, 0);
        chk("rst_mid_stretch", stretch, 0);
        addr = 6'h00;
        rw   = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        wait_rise("rerise", n);
        chk("rerise_delay", n, 25);
        chk("rerise_count", cyc_count, 1);

        // Counter wrap via preload
        dut.r_cycle_count = 16'hFFFE;
        measure("wrap_a", -1);
        chk("wrap_ffff", cyc_count, 32'h0000FFFF);
        measure("wrap_b", -1);
        chk("wrap_0000", cyc_count, 0);
        chk("wrap_cs", cyc_start, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
